// File: rtl/alu_multiciclo.sv
// rtl/alu_multiciclo.sv - multi-cycle ALU with start/busy/done handshake and registered NZCV flags
// MUL and DIV iterate one bit per CALC cycle; every other op finishes in one cycle.
module alu_multiciclo #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [2:0]   selec_alu,
   output logic [N-1:0] result,
   output logic         Neg,
   output logic         Z,
   output logic         C,
   output logic         V,
   output logic         busy,
   output logic         done
);

   localparam int CW = $clog2(N) + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_MUL  = 3'b010;
   localparam logic [2:0] OP_PASS = 3'b011;
   localparam logic [2:0] OP_AND  = 3'b100;
   localparam logic [2:0] OP_OR   = 3'b101;
   localparam logic [2:0] OP_DIV  = 3'b110;

   logic [1:0]     state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [2*N-1:0] acc_q, acc_d;
   logic [N-1:0]   opnd_q, opnd_d;
   logic [2:0]     op_q, op_d;
   logic [N-1:0]   result_q, result_d;
   logic           neg_q, neg_d;
   logic           z_q, z_d;
   logic           c_q, c_d;
   logic           v_q, v_d;

   logic [N:0]     add_w, sub_w, mul_sum_w, div_trial_w;
   logic [2*N-1:0] mul_step_w, div_step_w;
   logic           load_w;
   logic [N-1:0]   res_w;
   logic           c_w, v_w;

   assign add_w = {1'b0, a} + {1'b0, b};
   assign sub_w = {1'b0, a} - {1'b0, b};

   // MUL: acc = {partial product, remaining multiplier bits}, shifted right each step
   assign mul_sum_w  = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, opnd_q} : {(N+1){1'b0}});
   assign mul_step_w = {mul_sum_w, acc_q[N-1:1]};

   // DIV: acc = {remainder, dividend/quotient}, shifted left each step
   assign div_trial_w = {acc_q[2*N-1:N], acc_q[N-1]} - {1'b0, opnd_q};
   assign div_step_w  = div_trial_w[N] ? {acc_q[2*N-2:0], 1'b0}
                                       : {div_trial_w[N-1:0], acc_q[N-2:0], 1'b1};

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      opnd_d   = opnd_q;
      op_d     = op_q;
      load_w   = 1'b0;
      res_w    = '0;
      c_w      = 1'b0;
      v_w      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d  = selec_alu;
               cnt_d = CW'(N - 1);
               case (selec_alu)
                  OP_MUL: begin
                     state_d = S_CALC;
                     opnd_d  = a;
                     acc_d   = {{N{1'b0}}, b};
                  end
                  OP_DIV: begin
                     if (b == '0) begin
                        state_d = S_DONE;
                        load_w  = 1'b1;
                        res_w   = '1;
                        v_w     = 1'b1;
                     end else begin
                        state_d = S_CALC;
                        opnd_d  = b;
                        acc_d   = {{N{1'b0}}, a};
                     end
                  end
                  default: begin
                     state_d = S_DONE;
                     load_w  = 1'b1;
                     case (selec_alu)
                        OP_ADD: begin
                           res_w = add_w[N-1:0];
                           c_w   = add_w[N];
                           v_w   = (a[N-1] == b[N-1]) && (add_w[N-1] != a[N-1]);
                        end
                        OP_SUB: begin
                           res_w = sub_w[N-1:0];
                           c_w   = ~sub_w[N];
                           v_w   = (a[N-1] != b[N-1]) && (sub_w[N-1] != a[N-1]);
                        end
                        OP_PASS: res_w = b;
                        OP_AND:  res_w = a & b;
                        OP_OR:   res_w = a | b;
                        default: res_w = '0;
                     endcase
                  end
               endcase
            end
         end
         S_CALC: begin
            acc_d = (op_q == OP_MUL) ? mul_step_w : div_step_w;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == '0) begin
               state_d = S_DONE;
               load_w  = 1'b1;
               if (op_q == OP_MUL) begin
                  res_w = mul_step_w[N-1:0];
                  v_w   = |mul_step_w[2*N-1:N];
               end else begin
                  res_w = div_step_w[N-1:0];
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      result_d = load_w ? res_w : result_q;
      neg_d    = load_w ? res_w[N-1] : neg_q;
      z_d      = load_w ? (res_w == '0) : z_q;
      c_d      = load_w ? c_w : c_q;
      v_d      = load_w ? v_w : v_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         opnd_q   <= '0;
         op_q     <= '0;
         result_q <= '0;
         neg_q    <= 1'b0;
         z_q      <= 1'b0;
         c_q      <= 1'b0;
         v_q      <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         opnd_q   <= opnd_d;
         op_q     <= op_d;
         result_q <= result_d;
         neg_q    <= neg_d;
         z_q      <= z_d;
         c_q      <= c_d;
         v_q      <= v_d;
      end
   end

   assign result = result_q;
   assign Neg    = neg_q;
   assign Z      = z_q;
   assign C      = c_q;
   assign V      = v_q;
   assign busy   = (state_q == S_CALC);
   assign done   = (state_q == S_DONE);

endmodule

// File: tb/tb_alu_multiciclo.sv
// tb/tb_alu_multiciclo.sv - scoreboard bench for alu_multiciclo at N=8
module tb_alu_multiciclo;

   typedef struct packed {
      logic [7:0] res;
      logic       n;
      logic       z;
      logic       c;
      logic       v;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] a, b;
   logic [2:0] selec_alu;
   logic [7:0] result;
   logic       Neg, Z, C, V, busy, done;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   logic [7:0] last_res;

   alu_multiciclo #(.N(8)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .selec_alu(selec_alu),
      .result(result), .Neg(Neg), .Z(Z), .C(C), .V(V), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic exp_t mk(input logic [7:0] r, input logic c, input logic v);
      exp_t e;
      e.res = r; e.n = r[7]; e.z = (r == 8'h00); e.c = c; e.v = v;
      return e;
   endfunction

   // Reference behaviour written with plain arithmetic operators
   function automatic exp_t model(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
      logic [8:0]  s;
      logic [15:0] p;
      case (op)
         3'b000: begin s = {1'b0, x} + {1'b0, y};
                  return mk(s[7:0], s[8], (x[7] == y[7]) && (s[7] != x[7])); end
         3'b001: begin s = {1'b0, x - y};
                  return mk(s[7:0], x >= y, (x[7] != y[7]) && (s[7] != x[7])); end
         3'b010: begin p = 16'(x) * 16'(y); return mk(p[7:0], 1'b0, p[15:8] != 8'h00); end
         3'b011: return mk(y, 1'b0, 1'b0);
         3'b100: return mk(x & y, 1'b0, 1'b0);
         3'b101: return mk(x | y, 1'b0, 1'b0);
         3'b110: return (y == 8'h00) ? mk(8'hFF, 1'b0, 1'b1) : mk(x / y, 1'b0, 1'b0);
         default: return mk(8'h00, 1'b0, 1'b0);
      endcase
   endfunction

   task automatic do_op(input string tag, input logic [2:0] op, input logic [7:0] x,
                        input logic [7:0] y, input exp_t e, input int lat, input bit noise);
      int   cyc;
      exp_t got;
      @(negedge clk);
      start = 1'b1; a = x; b = y; selec_alu = op;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0; a = 8'($urandom); b = 8'($urandom); selec_alu = 3'($urandom);
      cyc = 1;
      while (done !== 1'b1 && cyc < 40) begin
         chk({tag, "_busy"}, busy, 1);
         chk({tag, "_held"}, result, last_res);
         if (noise) begin
            start = cyc[0]; a = 8'($urandom); b = 8'($urandom); selec_alu = 3'($urandom);
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      chk({tag, "_done"}, done, 1);
      chk({tag, "_latency"}, cyc, lat);
      chk({tag, "_busy_at_done"}, busy, 0);
      got = {result, Neg, Z, C, V};
      chk({tag, "_res_flags"}, got, sb.pop_front());
      last_res = e.res;
      @(negedge clk);
      chk({tag, "_done_pulse"}, done, 0);
      chk({tag, "_res_hold"}, result, last_res);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      logic [2:0] op;
      logic [7:0] x, y;
      rst = 1'b1; start = 1'b0; a = '0; b = '0; selec_alu = '0;
      last_res = 8'h00;
      #12;
      chk("reset_outputs", {result, Neg, Z, C, V, busy, done}, 0);
      @(negedge clk);
      rst = 1'b0;

      do_op("add_ovf",  3'b000, 8'h7F, 8'h01, mk(8'h80, 1'b0, 1'b1), 1, 0);
      do_op("sub_eq",   3'b001, 8'h05, 8'h05, mk(8'h00, 1'b1, 1'b0), 1, 0);
      do_op("sub_brw",  3'b001, 8'h03, 8'h05, mk(8'hFE, 1'b0, 1'b0), 1, 0);
      do_op("mul_ovf",  3'b010, 8'h10, 8'h11, mk(8'h10, 1'b0, 1'b1), 9, 0);
      do_op("mul_ok",   3'b010, 8'h0C, 8'h0A, mk(8'h78, 1'b0, 1'b0), 9, 0);
      do_op("div",      3'b110, 8'd200, 8'd7, mk(8'h1C, 1'b0, 1'b0), 9, 0);
      do_op("div0",     3'b110, 8'h55, 8'h00, mk(8'hFF, 1'b0, 1'b1), 1, 0);
      do_op("add_wrap", 3'b000, 8'hFF, 8'h01, mk(8'h00, 1'b1, 1'b0), 1, 0);
      do_op("pass_b",   3'b011, 8'h12, 8'h80, mk(8'h80, 1'b0, 1'b0), 1, 0);
      do_op("and",      3'b100, 8'hF0, 8'h3C, mk(8'h30, 1'b0, 1'b0), 1, 0);
      do_op("or",       3'b101, 8'h0F, 8'hF0, mk(8'hFF, 1'b0, 1'b0), 1, 0);
      do_op("rsvd",     3'b111, 8'hAA, 8'h55, mk(8'h00, 1'b0, 1'b0), 1, 0);
      do_op("div_small",3'b110, 8'd7, 8'd200, mk(8'h00, 1'b0, 1'b0), 9, 0);
      do_op("mul_max",  3'b010, 8'hFF, 8'hFF, mk(8'h01, 1'b0, 1'b1), 9, 0);
      do_op("mul_noise",3'b010, 8'h10, 8'h11, mk(8'h10, 1'b0, 1'b1), 9, 1);
      do_op("add_after",3'b000, 8'h20, 8'h22, mk(8'h42, 1'b0, 1'b0), 1, 0);

      for (int i = 0; i < 8; i++) begin
         op = 3'($urandom); x = 8'($urandom); y = 8'($urandom);
         e = model(op, x, y);
         do_op("rand", op, x, y, e,
               (op == 3'b010 || (op == 3'b110 && y != 8'h00)) ? 9 : 1, 0);
      end

      // Reset in the middle of a MUL aborts it without a done pulse
      @(negedge clk);
      start = 1'b1; a = 8'h33; b = 8'h44; selec_alu = 3'b010;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("mul_busy_before_rst", busy, 1);
      rst = 1'b1;
      #1;
      chk("rst_mid_outputs", {result, Neg, Z, C, V, busy, done}, 0);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (i == 2) rst = 1'b0;
         chk("rst_no_done", done, 0);
      end
      chk("rst_after_outputs", {result, Neg, Z, C, V, busy}, 0);
      last_res = 8'h00;
      do_op("add_post_rst", 3'b000, 8'h01, 8'h02, mk(8'h03, 1'b0, 1'b0), 1, 0);

      chk("scoreboard_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
